// File: rtl/doorlock_pkg.sv
// Shared definitions for the door-lock controller: state encodings, key codes
// and a small key-classification helper.
package doorlock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ENTRY    = 3'd1,
    ST_CHECK    = 3'd2,
    ST_UNLOCKED = 3'd3,
    ST_NEWPW    = 3'd4,
    ST_LOCKOUT  = 3'd5
  } state_e;

  localparam logic [3:0] KEY_CLEAR  = 4'hA;
  localparam logic [3:0] KEY_ENTER  = 4'hB;
  localparam logic [3:0] KEY_CHANGE = 4'hC;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/doorlock_pw_digit_counter.sv
// Two-bit digit index for the 4-digit entry buffer with a sticky full flag
// that is set when the index wraps from 3 back to 0.
module pw_digit_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  output logic [1:0] idx,
  output logic       full
);

  logic [1:0] idx_d, idx_q;
  logic       full_d, full_q;

  always_comb begin
    idx_d  = idx_q;
    full_d = full_q;
    if (clr) begin
      idx_d  = 2'd0;
      full_d = 1'b0;
    end else if (en && !full_q) begin
      idx_d = idx_q + 2'd1;
      if (idx_q == 2'd3) full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q  <= 2'd0;
      full_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      full_q <= full_d;
    end
  end

  assign idx  = idx_q;
  assign full = full_q;

endmodule

// File: rtl/doorlock_ctrl.sv
// Password-entry controller: collects keypad digits, checks them against the
// stored password, drives unlock/alarm and supports password change.
module doorlock_ctrl
  import doorlock_pkg::*;
#(
  parameter logic [15:0] DEFAULT_PW  = 16'h1234,
  parameter int          UNLOCK_CYC  = 1000,
  parameter int          MAX_FAIL    = 3,
  parameter int          LOCKOUT_CYC = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [1:0] digit_idx,
  output logic       unlock,
  output logic       alarm,
  output logic       ok_pulse,
  output logic       err_pulse,
  output logic [2:0] state_o
);

  localparam int TMR_MAX = (UNLOCK_CYC > LOCKOUT_CYC) ? UNLOCK_CYC : LOCKOUT_CYC;
  localparam int TIMER_W = $clog2(TMR_MAX) + 1;
  localparam logic [TIMER_W-1:0] UNLOCK_LD  = TIMER_W'(UNLOCK_CYC);
  localparam logic [TIMER_W-1:0] LOCKOUT_LD = TIMER_W'(LOCKOUT_CYC);
  localparam logic [2:0]         FAIL_LIMIT = 3'(MAX_FAIL);

  state_e             state_d, state_q;
  logic [15:0]        entry_d, entry_q;
  logic [15:0]        pw_d, pw_q;
  logic [2:0]         fail_cnt_d, fail_cnt_q;
  logic [TIMER_W-1:0] timer_d, timer_q;
  logic               short_d, short_q;
  logic               ok_d, ok_q;
  logic               err_d, err_q;
  logic               unlock_d, unlock_q;
  logic               alarm_d, alarm_q;

  logic               cnt_clr, cnt_en, digit_we;
  logic [1:0]         idx;
  logic               full;

  logic               key_digit, key_clear, key_enter, key_change;
  logic [TIMER_W-1:0] timer_dec;
  logic               expire;
  logic [2:0]         fail_inc;

  assign key_digit  = key_valid && is_digit(key_code);
  assign key_clear  = key_valid && (key_code == KEY_CLEAR);
  assign key_enter  = key_valid && (key_code == KEY_ENTER);
  assign key_change = key_valid && (key_code == KEY_CHANGE);

  // Saturating down-count shared by UNLOCKED and LOCKOUT
  assign timer_dec = (timer_q == '0) ? '0 : timer_q - 1'b1;
  assign expire    = (timer_dec == '0);
  assign fail_inc  = fail_cnt_q + 3'd1;

  pw_digit_counter u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .idx  (idx),
    .full (full)
  );

  always_comb begin
    state_d    = state_q;
    entry_d    = entry_q;
    pw_d       = pw_q;
    fail_cnt_d = fail_cnt_q;
    timer_d    = timer_q;
    short_d    = short_q;
    ok_d       = 1'b0;
    err_d      = 1'b0;
    cnt_clr    = 1'b0;
    digit_we   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (key_digit) begin
          digit_we = 1'b1;
          state_d  = ST_ENTRY;
        end
      end
      ST_ENTRY: begin
        if (key_digit) begin
          digit_we = 1'b1;
        end else if (key_clear) begin
          cnt_clr = 1'b1;
          entry_d = '0;
          state_d = ST_IDLE;
        end else if (key_enter) begin
          // A short entry still goes through CHECK so it takes the same fail path
          short_d = !full;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        cnt_clr = 1'b1;
        entry_d = '0;
        short_d = 1'b0;
        if (!short_q && (entry_q == pw_q)) begin
          ok_d       = 1'b1;
          fail_cnt_d = 3'd0;
          timer_d    = UNLOCK_LD;
          state_d    = ST_UNLOCKED;
        end else begin
          err_d      = 1'b1;
          fail_cnt_d = fail_inc;
          if (fail_inc >= FAIL_LIMIT) begin
            timer_d = LOCKOUT_LD;
            state_d = ST_LOCKOUT;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_UNLOCKED: begin
        timer_d = timer_dec;
        if (expire) begin
          state_d = ST_IDLE;
        end else if (key_clear) begin
          timer_d = '0;
          state_d = ST_IDLE;
        end else if (key_change) begin
          timer_d = '0;
          state_d = ST_NEWPW;
        end else if (key_digit || key_enter) begin
          timer_d = UNLOCK_LD;
        end
      end
      ST_NEWPW: begin
        if (key_digit) begin
          digit_we = 1'b1;
        end else if (key_enter) begin
          cnt_clr = 1'b1;
          entry_d = '0;
          state_d = ST_IDLE;
          if (full) begin
            pw_d = entry_q;
            ok_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else if (key_clear) begin
          cnt_clr = 1'b1;
          entry_d = '0;
          state_d = ST_IDLE;
        end
      end
      ST_LOCKOUT: begin
        timer_d = timer_dec;
        if (expire) begin
          fail_cnt_d = 3'd0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    cnt_en = digit_we;
    if (digit_we && !full) begin
      case (idx)
        2'd0:    entry_d[15:12] = key_code;
        2'd1:    entry_d[11:8]  = key_code;
        2'd2:    entry_d[7:4]   = key_code;
        default: entry_d[3:0]   = key_code;
      endcase
    end

    unlock_d = (state_d == ST_UNLOCKED);
    alarm_d  = (state_d == ST_LOCKOUT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      entry_q    <= '0;
      pw_q       <= DEFAULT_PW;
      fail_cnt_q <= 3'd0;
      timer_q    <= '0;
      short_q    <= 1'b0;
      ok_q       <= 1'b0;
      err_q      <= 1'b0;
      unlock_q   <= 1'b0;
      alarm_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      entry_q    <= entry_d;
      pw_q       <= pw_d;
      fail_cnt_q <= fail_cnt_d;
      timer_q    <= timer_d;
      short_q    <= short_d;
      ok_q       <= ok_d;
      err_q      <= err_d;
      unlock_q   <= unlock_d;
      alarm_q    <= alarm_d;
    end
  end

  assign digit_idx = idx;
  assign unlock    = unlock_q;
  assign alarm     = alarm_q;
  assign ok_pulse  = ok_q;
  assign err_pulse = err_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_doorlock_ctrl.sv
// Scoreboard bench for doorlock_ctrl: directed scenarios plus random keys,
// predicted by a queue-based behavioural model of the lock.
module tb_doorlock_ctrl;

  localparam int UC = 8;
  localparam int MF = 3;
  localparam int LC = 16;

  localparam int S_IDLE = 0, S_ENTRY = 1, S_CHECK = 2, S_UNLOCKED = 3, S_NEWPW = 4, S_LOCKOUT = 5;
  localparam int K_CLEAR = 10, K_ENTER = 11, K_CHANGE = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic [1:0] digit_idx;
  logic       unlock, alarm, ok_pulse, err_pulse;
  logic [2:0] state_o;

  always #5 clk = ~clk;

  doorlock_ctrl #(
    .DEFAULT_PW (16'h1234),
    .UNLOCK_CYC (UC),
    .MAX_FAIL   (MF),
    .LOCKOUT_CYC(LC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_valid(key_valid),
    .key_code (key_code),
    .digit_idx(digit_idx),
    .unlock   (unlock),
    .alarm    (alarm),
    .ok_pulse (ok_pulse),
    .err_pulse(err_pulse),
    .state_o  (state_o)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       unl;
    logic       alm;
    logic [1:0] idx;
    logic       ok;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Behavioural model: entered digits as a queue, password as an integer
  int m_st = S_IDLE;
  int m_digits[$];
  int m_fails = 0;
  int m_pw = 'h1234;
  int m_rem = 0;

  function automatic int pack_digits();
    int v = 0;
    foreach (m_digits[i]) v = v * 16 + m_digits[i];
    return v;
  endfunction

  task automatic model_step(input logic r, input logic kv, input logic [3:0] kc);
    bit   ok = 0;
    bit   err = 0;
    bit   dig;
    bit   pass;
    int   code;
    exp_t e;
    code = int'(kc);
    dig  = kv && (code <= 9);
    if (r) begin
      m_st = S_IDLE;
      m_digits.delete();
      m_fails = 0;
      m_pw = 'h1234;
      m_rem = 0;
    end else begin
      case (m_st)
        S_IDLE: begin
          if (dig) begin
            m_digits.push_back(code);
            m_st = S_ENTRY;
          end
        end
        S_ENTRY, S_NEWPW: begin
          if (dig) begin
            if (m_digits.size() < 4) m_digits.push_back(code);
          end else if (kv && code == K_CLEAR) begin
            m_digits.delete();
            m_st = S_IDLE;
          end else if (kv && code == K_ENTER) begin
            if (m_st == S_ENTRY) begin
              m_st = S_CHECK;
            end else begin
              if (m_digits.size() == 4) begin
                m_pw = pack_digits();
                ok = 1;
              end else begin
                err = 1;
              end
              m_digits.delete();
              m_st = S_IDLE;
            end
          end
        end
        S_CHECK: begin
          pass = (m_digits.size() == 4) && (pack_digits() == m_pw);
          m_digits.delete();
          if (pass) begin
            ok = 1;
            m_fails = 0;
            m_rem = UC;
            m_st = S_UNLOCKED;
          end else begin
            err = 1;
            m_fails++;
            if (m_fails >= MF) begin
              m_rem = LC;
              m_st = S_LOCKOUT;
            end else begin
              m_st = S_IDLE;
            end
          end
        end
        S_UNLOCKED: begin
          m_rem--;
          if (m_rem == 0) m_st = S_IDLE;
          else if (kv && code == K_CLEAR) m_st = S_IDLE;
          else if (kv && code == K_CHANGE) m_st = S_NEWPW;
          else if (dig || (kv && code == K_ENTER)) m_rem = UC;
        end
        S_LOCKOUT: begin
          m_rem--;
          if (m_rem == 0) begin
            m_fails = 0;
            m_st = S_IDLE;
          end
        end
        default: m_st = S_IDLE;
      endcase
    end
    e.st  = m_st[2:0];
    e.unl = (m_st == S_UNLOCKED);
    e.alm = (m_st == S_LOCKOUT);
    e.idx = 2'(m_digits.size() % 4);
    e.ok  = ok;
    e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  // Monitor: the DUT presents its status every cycle; compare on the falling edge
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("state_o",   16'(state_o),   16'(e.st));
      chk("unlock",    16'(unlock),    16'(e.unl));
      chk("alarm",     16'(alarm),     16'(e.alm));
      chk("digit_idx", 16'(digit_idx), 16'(e.idx));
      chk("ok_pulse",  16'(ok_pulse),  16'(e.ok));
      chk("err_pulse", 16'(err_pulse), 16'(e.err));
    end
  end

  task automatic tick(input logic r, input logic kv, input logic [3:0] kc);
    @(negedge clk);
    #1;
    rst       = r;
    key_valid = kv;
    key_code  = kc;
    @(posedge clk);
    model_step(r, kv, kc);
  endtask

  task automatic press(input int k);
    tick(1'b0, 1'b1, 4'(k));
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 1'b0, 4'd0);
  endtask

  task automatic do_reset();
    tick(1'b1, 1'b0, 4'd0);
    tick(1'b1, 1'b0, 4'd0);
  endtask

  task automatic type_pw(input int v);
    for (int i = 3; i >= 0; i--) press((v >> (4 * i)) & 'hF);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset();
    idle(2);

    // Correct default password, then let unlock time out
    type_pw('h1234); press(K_ENTER); idle(12);

    // Three wrong attempts -> lockout, keys ignored, then unlock
    do_reset();
    for (int a = 0; a < 3; a++) begin
      type_pw('h9999); press(K_ENTER); idle(2);
    end
    for (int i = 0; i < 10; i++) press(i);
    idle(6);
    type_pw('h1234); press(K_ENTER); idle(3);

    // Password change, old fails, new unlocks; trailing-zero password
    do_reset();
    type_pw('h1234); press(K_ENTER); idle(2);
    press(K_CHANGE); type_pw('h5678); press(K_ENTER); idle(2);
    type_pw('h1234); press(K_ENTER); idle(2);
    type_pw('h5678); press(K_ENTER); idle(2);
    press(K_CHANGE); type_pw('h1200); press(K_ENTER); idle(1);
    press(1); press(2); press(K_ENTER); idle(2);
    type_pw('h1200); press(K_ENTER); idle(2);
    press(K_CHANGE); press(5); press(6); press(K_ENTER); idle(1);
    type_pw('h1200); press(K_ENTER); idle(2); press(K_CLEAR); idle(1);

    // Short entry fails; fifth digit ignored
    do_reset();
    press(1); press(2); press(K_ENTER); idle(2);
    press(1); press(2); press(3); press(4); press(5); press(K_ENTER); idle(3);
    press(K_CLEAR); idle(1);

    // CLEAR during entry; key coinciding with unlock expiry
    press(1); press(2); press(K_CLEAR); idle(1);
    type_pw('h1234); press(K_ENTER); idle(1); idle(UC - 1); press(3); idle(2);

    // Reset in NEWPW restores default password
    type_pw('h1234); press(K_ENTER); idle(1);
    press(K_CHANGE); press(5); press(6);
    tick(1'b1, 1'b0, 4'd0);
    idle(1);
    type_pw('h1234); press(K_ENTER); idle(3);

    // Random keys with occasional correct entries and password changes
    for (int n = 0; n < 300; n++) begin
      int sel;
      sel = $urandom_range(0, 19);
      if (sel < 4) begin
        type_pw(m_pw); press(K_ENTER); idle($urandom_range(0, 3));
      end else if (sel == 4) begin
        press(K_CHANGE);
        type_pw($urandom_range(0, 9) * 'h1000 + $urandom_range(0, 9) * 'h100 +
                $urandom_range(0, 9) * 'h10 + $urandom_range(0, 9));
        press(K_ENTER);
      end else if (sel == 5 && $urandom_range(0, 9) == 0) begin
        tick(1'b1, 1'b0, 4'd0);
      end else begin
        tick(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      end
    end
    idle(3);

    @(negedge clk);
    #2;
    chk("scoreboard_drain", 16'(exp_q.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
